frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 146 ++++++++++++++
 tb/tb_frame_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: per frame tick, erase the object, move it one bounce step, redraw it.
// Optional build macro FRAME_SEQ_PAUSE_EN adds a pause input that holds off new frames in IDLE.
module frame_sequencer #(
  parameter logic [7:0] X_MAX  = 8'd159,
  parameter logic [6:0] Y_MAX  = 7'd119,
  parameter int         STEP   = 1,
  parameter logic [2:0] COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic       plot_ack,
`ifdef FRAME_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic       plot_req,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic [7:0] frame_count,
  output logic [3:0] missed_ticks
);

  typedef enum logic [1:0] {IDLE, ERASE, MOVE, DRAW} state_t;

  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [6:0] STEP7 = 7'(STEP);

  state_t     state_reg, state_next;
  logic [7:0] x_reg, x_next;
  logic [6:0] y_reg, y_next;
  logic       x_right_reg, x_right_next;
  logic       y_down_reg, y_down_next;
  logic [7:0] frame_count_reg;
  logic [3:0] missed_reg;
  logic [8:0] x_sum, y_sum;
  logic       start_frame;

`ifdef FRAME_SEQ_PAUSE_EN
  assign start_frame = tick && !pause;
`else
  assign start_frame = tick;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_frame) state_next = ERASE;
      ERASE:   if (plot_ack)    state_next = MOVE;
      MOVE:                     state_next = DRAW;
      DRAW:    if (plot_ack)    state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_comb begin
    plot_req = 1'b0;
    colour   = 3'b000;
    case (state_reg)
      ERASE:   plot_req = 1'b1;
      DRAW: begin
        plot_req = 1'b1;
        colour   = COLOUR;
      end
      default: ;
    endcase
  end

  // Widened sums so a step past the edge near 255 cannot wrap before the bound test.
  assign x_sum = {1'b0, x_reg} + STEP9;
  assign y_sum = {2'b00, y_reg} + STEP9;

  always_comb begin
    x_next       = x_reg;
    y_next       = y_reg;
    x_right_next = x_right_reg;
    y_down_next  = y_down_reg;
    if (state_reg == MOVE) begin
      if (x_right_reg) begin
        if (x_sum > {1'b0, X_MAX}) begin
          x_next       = X_MAX;
          x_right_next = 1'b0;
        end else begin
          x_next = x_sum[7:0];
        end
      end else if ({1'b0, x_reg} < STEP9) begin
        x_next       = 8'd0;
        x_right_next = 1'b1;
      end else begin
        x_next = x_reg - STEP8;
      end

      if (y_down_reg) begin
        if (y_sum > {2'b00, Y_MAX}) begin
          y_next      = Y_MAX;
          y_down_next = 1'b0;
        end else begin
          y_next = y_sum[6:0];
        end
      end else if ({2'b00, y_reg} < STEP9) begin
        y_next      = 7'd0;
        y_down_next = 1'b1;
      end else begin
        y_next = y_reg - STEP7;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_reg           <= 8'd0;
      y_reg           <= 7'd0;
      x_right_reg     <= 1'b1;
      y_down_reg      <= 1'b1;
      frame_count_reg <= 8'd0;
      missed_reg      <= 4'd0;
    end else begin
      x_reg       <= x_next;
      y_reg       <= y_next;
      x_right_reg <= x_right_next;
      y_down_reg  <= y_down_next;
      if (state_reg == DRAW && plot_ack) begin
        frame_count_reg <= frame_count_reg + 8'd1;
      end
      // Ticks are never queued; any tick seen outside IDLE is lost and counted.
      if (tick && state_reg != IDLE && missed_reg != 4'd15) begin
        missed_reg <= missed_reg + 4'd1;
      end
    end
  end

  assign x            = x_reg;
  assign y            = y_reg;
  assign frame_count  = frame_count_reg;
  assign missed_ticks = missed_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: directed stimulus on a default instance and a small-field STEP=4 instance,
// checked every cycle against a frame-level model plus hand-computed pins.
module tb_frame_sequencer;

  logic clock;
  logic resetn;
  logic tick;
  logic plot_ack;
`ifdef FRAME_SEQ_PAUSE_EN
  logic pause;
`endif

  logic       plot_req_o    [2];
  logic [7:0] x_o           [2];
  logic [6:0] y_o           [2];
  logic [2:0] colour_o      [2];
  logic [7:0] frame_count_o [2];
  logic [3:0] missed_o      [2];

  int n_pass;
  int n_total;

  frame_sequencer u_dut (
    .clock        (clock),
    .resetn       (resetn),
    .tick         (tick),
    .plot_ack     (plot_ack),
`ifdef FRAME_SEQ_PAUSE_EN
    .pause        (pause),
`endif
    .plot_req     (plot_req_o[0]),
    .x            (x_o[0]),
    .y            (y_o[0]),
    .colour       (colour_o[0]),
    .frame_count  (frame_count_o[0]),
    .missed_ticks (missed_o[0])
  );

  frame_sequencer #(
    .X_MAX (8'd10),
    .Y_MAX (7'd6),
    .STEP  (4)
  ) u_small (
    .clock        (clock),
    .resetn       (resetn),
    .tick         (tick),
    .plot_ack     (plot_ack),
`ifdef FRAME_SEQ_PAUSE_EN
    .pause        (pause),
`endif
    .plot_req     (plot_req_o[1]),
    .x            (x_o[1]),
    .y            (y_o[1]),
    .colour       (colour_o[1]),
    .frame_count  (frame_count_o[1]),
    .missed_ticks (missed_o[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Frame-level model: phase 0 waiting, 1 erasing, 2 moving, 3 drawing.
  int m_ph [2];
  int m_x  [2];
  int m_y  [2];
  int m_dx [2];
  int m_dy [2];
  int m_fc [2];
  int m_mt [2];
  int xmax [2] = '{159, 10};
  int ymax [2] = '{119, 6};
  int stp  [2] = '{1, 4};
  bit m_valid;

  function automatic void bounce(inout int p, inout int d, input int mx, input int st);
    int t;
    t = p + d * st;
    if (t > mx) begin
      p = mx;
      d = -1;
    end else if (t < 0) begin
      p = 0;
      d = 1;
    end else begin
      p = t;
    end
  endfunction

  initial begin
    bit r, t, a, p;
    m_valid = 0;
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dx[i] = 1; m_dy[i] = 1; m_fc[i] = 0; m_mt[i] = 0;
    end
    forever begin
      @(posedge clock);
      r = resetn;
      t = tick;
      a = plot_ack;
`ifdef FRAME_SEQ_PAUSE_EN
      p = pause;
`else
      p = 0;
`endif
      for (int i = 0; i < 2; i++) begin
        if (!r) begin
          m_ph[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dx[i] = 1; m_dy[i] = 1; m_fc[i] = 0; m_mt[i] = 0;
        end else begin
          if (t && m_ph[i] != 0 && m_mt[i] < 15) m_mt[i]++;
          case (m_ph[i])
            0: if (t && !p) m_ph[i] = 1;
            1: if (a) m_ph[i] = 2;
            2: begin
              bounce(m_x[i], m_dx[i], xmax[i], stp[i]);
              bounce(m_y[i], m_dy[i], ymax[i], stp[i]);
              m_ph[i] = 3;
            end
            default: if (a) begin
              m_fc[i] = (m_fc[i] + 1) % 256;
              m_ph[i] = 0;
            end
          endcase
        end
      end
      if (!r) m_valid = 1;
      @(negedge clock);
      if (m_valid) begin
        for (int i = 0; i < 2; i++) begin
          check($sformatf("u%0d.plot_req", i), int'(plot_req_o[i]), (m_ph[i] == 1 || m_ph[i] == 3) ? 1 : 0);
          check($sformatf("u%0d.colour", i), int'(colour_o[i]), (m_ph[i] == 3) ? 7 : 0);
          check($sformatf("u%0d.x", i), int'(x_o[i]), m_x[i]);
          check($sformatf("u%0d.y", i), int'(y_o[i]), m_y[i]);
          check($sformatf("u%0d.frame_count", i), int'(frame_count_o[i]), m_fc[i]);
          check($sformatf("u%0d.missed_ticks", i), int'(missed_o[i]), m_mt[i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_frame();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    step();
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    resetn   = 1'b0;
    tick     = 1'b0;
    plot_ack = 1'b0;
`ifdef FRAME_SEQ_PAUSE_EN
    pause    = 1'b0;
`endif
    step();
    step();
    check("reset plot_req", int'(plot_req_o[0]), 0);
    check("reset x", int'(x_o[0]), 0);
    check("reset y", int'(y_o[0]), 0);
    check("reset colour", int'(colour_o[0]), 0);
    check("reset frame_count", int'(frame_count_o[0]), 0);
    check("reset missed", int'(missed_o[0]), 0);

    // One tick with acknowledge held: erase at origin, redraw one step on.
    resetn   = 1'b1;
    tick     = 1'b1;
    plot_ack = 1'b1;
    step();
    $display("txn single frame: erase cycle");
    check("erase plot_req", int'(plot_req_o[0]), 1);
    check("erase x", int'(x_o[0]), 0);
    check("erase colour", int'(colour_o[0]), 0);
    tick = 1'b0;
    step();
    check("move plot_req", int'(plot_req_o[0]), 0);
    step();
    check("draw plot_req", int'(plot_req_o[0]), 1);
    check("draw x", int'(x_o[0]), 1);
    check("draw y", int'(y_o[0]), 1);
    check("draw colour", int'(colour_o[0]), 7);
    check("small draw x", int'(x_o[1]), 4);
    step();
    check("frame_count after 1", int'(frame_count_o[0]), 1);
    check("idle plot_req", int'(plot_req_o[0]), 0);

    // Held erase with ticks arriving meanwhile, then saturation.
    plot_ack = 1'b0;
    tick     = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      tick = (i < 3);
      step();
    end
    $display("txn stalled erase: 3 ticks while busy");
    check("stall plot_req", int'(plot_req_o[0]), 1);
    check("stall x", int'(x_o[0]), 1);
    check("stall y", int'(y_o[0]), 1);
    check("stall missed", int'(missed_o[0]), 3);
    tick = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("missed saturate", int'(missed_o[0]), 15);
    tick     = 1'b0;
    plot_ack = 1'b1;
    step();
    step();
    step();
    $display("txn stalled frame completes");
    check("frame_count after 2", int'(frame_count_o[0]), 2);
    check("x after 2", int'(x_o[0]), 2);
    check("small x after 2", int'(x_o[1]), 8);
    check("small y after 2", int'(y_o[1]), 6);

    // Reset landing in the middle of a DRAW handshake.
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    plot_ack = 1'b0;
    step();
    check("held draw plot_req", int'(plot_req_o[0]), 1);
    check("held draw x", int'(x_o[0]), 3);
    resetn = 1'b0;
    step();
    $display("txn reset during draw");
    check("midreset plot_req", int'(plot_req_o[0]), 0);
    check("midreset x", int'(x_o[0]), 0);
    check("midreset y", int'(y_o[0]), 0);
    check("midreset frame_count", int'(frame_count_o[0]), 0);
    check("midreset missed", int'(missed_o[0]), 0);
    tick     = 1'b1;
    plot_ack = 1'b1;
    step();
    check("tick ignored in reset", int'(plot_req_o[0]), 0);

    // First tick on the first released edge starts a frame; then 256 frames.
    resetn = 1'b1;
    step();
    check("first tick accepted", int'(plot_req_o[0]), 1);
    tick = 1'b0;
    step();
    step();
    step();
    for (int f = 2; f <= 256; f++) begin
      do_frame();
      check("x in range", int'(x_o[0] <= 8'd159), 1);
      check("y in range", int'(y_o[0] <= 7'd119), 1);
      case (f)
        6:   check("small x left to 0", int'(x_o[1]), 0);
        7:   check("small x right again", int'(x_o[1]), 4);
        158: begin
          check("x at 158", int'(x_o[0]), 158);
          check("y at 158", int'(y_o[0]), 81);
        end
        159: check("x reaches 159", int'(x_o[0]), 159);
        160: check("x clamps 159", int'(x_o[0]), 159);
        161: check("x turns to 158", int'(x_o[0]), 158);
        default: ;
      endcase
    end
    $display("txn 256 frames done");
    check("frame_count wraps", int'(frame_count_o[0]), 0);
    check("missed after frames", int'(missed_o[0]), 0);

`ifdef FRAME_SEQ_PAUSE_EN
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      step();
      check("paused no plot_req", int'(plot_req_o[0]), 0);
      tick = 1'b0;
      step();
    end
    check("paused missed", int'(missed_o[0]), 0);
    pause = 1'b0;
    tick  = 1'b1;
    step();
    tick = 1'b0;
    step();
    pause = 1'b1;
    step();
    check("pause mid draw", int'(plot_req_o[0]), 1);
    step();
    check("pause frame done", int'(frame_count_o[0]), 1);
    pause = 1'b0;
    $display("txn pause checks done");
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
